// File: rtl/instr_mem_responder.sv
// Instruction memory responder: loader-writable word store serving one fetch at a time
// with a fixed WAIT_CYCLES latency. Define IMEM_MISALIGN_CHECK_EN to flag misaligned fetches.
module instr_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic        rsp_err,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int          IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_WORDS = 30'(DEPTH);
  localparam logic [3:0]  WAIT_INIT   = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  wait_cnt;
  logic [3:0]  wait_cnt_next;
  logic [31:0] addr_q;
  logic        capture;
  logic        rd_en;

  logic [31:0] rd_addr;
  logic        rd_in_range;
  logic        rd_bad;
  logic [31:0] rd_word;
  logic        ld_in_range;
  logic        unused_bits;

  logic [31:0] mem [DEPTH] = '{default: '0};

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_cnt_next;
      if (capture) begin
        addr_q <= req_addr;
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    next_state    = state;
    wait_cnt_next = wait_cnt;
    capture       = 1'b0;
    rd_en         = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          if (WAIT_INIT == 4'd0) begin
            next_state = RESP;
            rd_en      = 1'b1;
          end else begin
            next_state    = WAIT;
            wait_cnt_next = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        wait_cnt_next = wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) begin
          next_state = RESP;
          rd_en      = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // ---------------------------------------------------------------------------
  // Read path: a zero-wait fetch reads on its own accept edge, so the live
  // request address is used in IDLE and the captured one otherwise.
  // ---------------------------------------------------------------------------
  assign rd_addr     = (state == IDLE) ? req_addr : addr_q;
  assign rd_in_range = (rd_addr[31:2] < DEPTH_WORDS);
  assign rd_word     = mem[rd_addr[IDX_W+1:2]];
  assign ld_in_range = (ld_addr[31:2] < DEPTH_WORDS);

`ifdef IMEM_MISALIGN_CHECK_EN
  assign rd_bad      = !rd_in_range || (rd_addr[1:0] != 2'b00);
  assign unused_bits = ^ld_addr[1:0];
`else
  assign rd_bad      = !rd_in_range;
  assign unused_bits = ^{ld_addr[1:0], rd_addr[1:0]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_instr <= '0;
      rsp_err   <= 1'b0;
    end else if (rd_en) begin
      rsp_instr <= rd_bad ? 32'h0000_0000 : rd_word;
      rsp_err   <= rd_bad;
    end
  end

  // ---------------------------------------------------------------------------
  // Loader port. A write and a read of the same word on one edge return the
  // old word because the read register samples mem before the update lands.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the memory array is deliberately kept out of reset; reset only
    // clears control state, and program contents survive it.
    if (ld_we && ld_in_range) begin
      mem[ld_addr[IDX_W+1:2]] <= ld_data;
    end
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench for instr_mem_responder: the driver queues expected responses,
// an independent monitor checks data, stability and latency on every valid cycle.
module tb_instr_mem_responder;

  localparam int DEPTH       = 256;
  localparam int WAIT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic        rsp_err;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  instr_mem_responder #(
    .DEPTH      (DEPTH),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr),
    .rsp_err  (rsp_err),
    .ld_we    (ld_we),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   last_pop   = -100;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: samples on the falling edge, compares every valid cycle against
  // the head of the scoreboard and pops on the handoff cycle.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      check("rsp_expected", {31'b0, (sb.size() != 0)}, 32'd1);
      if (sb.size() != 0) begin
        if (!prev_valid) begin
          check("latency", 32'(cyc - sb[0].acc), 32'(WAIT_CYCLES + 1));
        end
        check("rsp_instr", rsp_instr, sb[0].instr);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, sb[0].err});
        if (rsp_ready) begin
          void'(sb.pop_front());
          last_pop = cyc;
        end
      end
    end
    prev_valid = rsp_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] data);
    ld_we   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    step();
    ld_we   = 1'b0;
  endtask

  // Drives a request until accepted; acc is the cycle count just before the accept edge.
  task automatic issue(input logic [31:0] addr, input logic [31:0] instr, input logic err,
                       input bit expect_rsp, output int acc);
    bit   done = 1'b0;
    exp_t e;
    req_valid = 1'b1;
    req_addr  = addr;
    acc       = -1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (req_ready) begin
        acc     = cyc;
        e.instr = instr;
        e.err   = err;
        e.acc   = cyc;
        if (expect_rsp) sb.push_back(e);
        done = 1'b1;
      end
      step();
    end
    req_valid = 1'b0;
    check("req_accepted", {31'b0, done}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 100) begin
      step();
      n++;
    end
    check("drain_in_time", {31'b0, (n < 100)}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    int acc2;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b1;
    ld_we     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;

    #2;
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_rsp_instr", rsp_instr, 32'd0);
    check("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("reset_req_ready", {31'b0, req_ready}, 32'd1);
    step();
    step();
    rst = 1'b0;

    load(32'h0000_0004, 32'h2002_0005);
    load(32'h0000_0008, 32'h1234_5678);
    load(32'h0000_0000, 32'hA5A5_0001);
    load(32'h0000_03FC, 32'hDEAD_BEEF);
    load(32'h0000_0400, 32'h0BAD_0BAD);  // out of range: must not alias word 0

    issue(32'h0000_0004, 32'h2002_0005, 1'b0, 1'b1, acc);
    issue(32'h0000_0000, 32'hA5A5_0001, 1'b0, 1'b1, acc);
    issue(32'h0000_03FC, 32'hDEAD_BEEF, 1'b0, 1'b1, acc);
    issue(32'h0000_0400, 32'h0000_0000, 1'b1, 1'b1, acc);
    issue(32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 1'b1, acc);
`ifdef IMEM_MISALIGN_CHECK_EN
    issue(32'h0000_0006, 32'h0000_0000, 1'b1, 1'b1, acc);
`else
    issue(32'h0000_0006, 32'h2002_0005, 1'b0, 1'b1, acc);
`endif
    wait_idle();

    // Back-pressure: five valid cycles with rsp_ready low, stray request ignored.
    rsp_ready = 1'b0;
    issue(32'h0000_0000, 32'hA5A5_0001, 1'b0, 1'b1, acc);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0400;
    repeat (WAIT_CYCLES + 5) step();
    check("ready_low_in_resp", {31'b0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    issue(32'h0000_0004, 32'h2002_0005, 1'b0, 1'b1, acc2);
    check("one_bubble_after_handoff", 32'(acc2 - last_pop), 32'd1);
    wait_idle();

    // Loader write on the RESP-entry edge: old data returned, new data afterwards.
    issue(32'h0000_0008, 32'h1234_5678, 1'b0, 1'b1, acc);
    repeat (WAIT_CYCLES - 1) step();
    load(32'h0000_0008, 32'hFFFF_FFFF);
    issue(32'h0000_0008, 32'hFFFF_FFFF, 1'b0, 1'b1, acc);
    wait_idle();

    // Reset while waiting: in-flight fetch dropped, outputs cleared asynchronously.
    issue(32'h0000_0004, 32'h2002_0005, 1'b0, 1'b0, acc);
    rst = 1'b1;
    #1;
    check("async_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("async_rst_rsp_instr", rsp_instr, 32'd0);
    check("async_rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("async_rst_req_ready", {31'b0, req_ready}, 32'd1);
    step();
    step();
    rst = 1'b0;
    repeat (8) step();
    check("ready_after_rst", {31'b0, req_ready}, 32'd1);
    issue(32'h0000_0004, 32'h2002_0005, 1'b0, 1'b1, acc);
    issue(32'h0000_0008, 32'hFFFF_FFFF, 1'b0, 1'b1, acc);
    wait_idle();
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
